// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit processor: address width, reset vector, return-stack depth.
package cpu_pkg;
    localparam int          CPU_AW          = 8;
    localparam logic [7:0]  CPU_RESET_ADDR  = 8'h00;
    localparam int          CPU_STACK_DEPTH = 4;
endpackage

// File: rtl/ret_stack.sv
// Parameterised LIFO of return addresses; storage is not reset, only the occupancy count.
import cpu_pkg::*;

module ret_stack #(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = CPU_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] top_idx;

    assign top_idx = PW'(count - CW'(1));
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop && !full) begin
            count <= count + CW'(1);
        end else if (pop && !push && !empty) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            mem[count[PW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter stage with jump load and optional call/return stack.
// Return stack built only when PC_RET_STACK_EN is defined.
import cpu_pkg::*;

module pc_unit #(
    parameter int            AW          = CPU_AW,
    parameter logic [AW-1:0] RESET_ADDR  = CPU_RESET_ADDR,
    parameter int            STACK_DEPTH = CPU_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] jump_addr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus1,
    output logic          stack_empty,
    output logic          stack_full,
    output logic          stack_err
);
    logic [AW-1:0] pc_next;

    assign pc_plus1 = pc + AW'(1);

`ifdef PC_RET_STACK_EN
    logic [AW-1:0] stk_top;
    logic          push;
    logic          pop;
    logic          err_set;

    // ret always wins; a call alongside ret is dropped and flagged
    assign push    = en && call && !ret && !stack_full;
    assign pop     = en && ret && !stack_empty;
    assign err_set = en && ((ret && stack_empty) || (call && ret) || (call && !ret && stack_full));

    ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1),
        .top   (stk_top),
        .empty (stack_empty),
        .full  (stack_full)
    );

    always_comb begin
        pc_next = pc_plus1;
        if (ret) begin
            pc_next = stack_empty ? pc_plus1 : stk_top;
        end else if (call || load) begin
            pc_next = jump_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end
    end
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic unused_ret;

    assign unused_ret  = ret;
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;

    always_comb begin
        pc_next = pc_plus1;
        if (call || load) begin
            pc_next = jump_addr;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else if (en) begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expectations follow whichever build (PC_RET_STACK_EN) is compiled.
module tb_pc_unit;
`ifdef PC_RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic l, input logic c, input logic r, input logic [7:0] j);
        en = 1'b1; load = l; call = c; ret = r; jump_addr = j;
        tick();
        load = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        check("rst_pc", pc, 8'h00);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_err", stack_err, 1'b0);
        rst_n = 1'b1;
        en = 1'b1;

        tick(); check("inc1", pc, 8'h01);
        tick(); check("inc2", pc, 8'h02);
        tick(); check("inc3", pc, 8'h03);
        check("plus1", pc_plus1, 8'h04);
        rst_n = 1'b0;
        #1;
        check("async_rst", pc, 8'h00);
        #1;
        rst_n = 1'b1;

        op(1'b1, 1'b0, 1'b0, 8'hFE); check("load_fe", pc, 8'hFE);
        tick(); check("inc_ff", pc, 8'hFF);
        tick(); check("wrap_00", pc, 8'h00);
        check("wrap_plus1", pc_plus1, 8'h01);
        check("wrap_err", stack_err, 1'b0);
        en = 1'b0;
        tick(); tick(); check("stall_hold", pc, 8'h00);
        load = 1'b1; jump_addr = 8'h55;
        tick(); check("stall_ignore_load", pc, 8'h00);
        load = 1'b0;

        op(1'b1, 1'b0, 1'b0, 8'h10);
        op(1'b1, 1'b0, 1'b0, 8'h40);
        check("load_40", pc, 8'h40);
        check("load_empty", stack_empty, 1'b1);

        op(1'b1, 1'b0, 1'b0, 8'h10);
        op(1'b0, 1'b1, 1'b0, 8'h80);
        check("call_80", pc, 8'h80);
        check("call_empty", stack_empty, STK ? 1'b0 : 1'b1);
        tick(); tick(); tick();
        check("sub_inc", pc, 8'h83);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        check("ret_11", pc, STK ? 8'h11 : 8'h84);
        check("ret_empty", stack_empty, 1'b1);

        op(1'b1, 1'b0, 1'b0, 8'h20);
        op(1'b0, 1'b1, 1'b0, 8'h30);
        op(1'b0, 1'b1, 1'b0, 8'h40);
        op(1'b0, 1'b1, 1'b0, 8'h50);
        op(1'b0, 1'b1, 1'b0, 8'h60);
        check("nest_pc", pc, 8'h60);
        check("nest_full", stack_full, STK ? 1'b1 : 1'b0);
        check("nest_err0", stack_err, 1'b0);
        op(1'b0, 1'b1, 1'b0, 8'h90);
        check("ovf_pc", pc, 8'h90);
        check("ovf_err", stack_err, STK ? 1'b1 : 1'b0);
        check("ovf_full", stack_full, STK ? 1'b1 : 1'b0);
        op(1'b0, 1'b0, 1'b1, 8'h00); check("pop_51", pc, STK ? 8'h51 : 8'h91);
        op(1'b0, 1'b0, 1'b1, 8'h00); check("pop_41", pc, STK ? 8'h41 : 8'h92);
        op(1'b0, 1'b0, 1'b1, 8'h00); check("pop_31", pc, STK ? 8'h31 : 8'h93);
        op(1'b0, 1'b0, 1'b1, 8'h00); check("pop_21", pc, STK ? 8'h21 : 8'h94);
        check("pop_empty", stack_empty, 1'b1);

        do_reset();
        check("err_cleared", stack_err, 1'b0);
        op(1'b1, 1'b0, 1'b0, 8'h05);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        check("udf_pc", pc, 8'h06);
        check("udf_err", stack_err, STK ? 1'b1 : 1'b0);

        do_reset();
        op(1'b1, 1'b0, 1'b0, 8'h32);
        op(1'b0, 1'b1, 1'b0, 8'h70);
        check("pre_conflict_pc", pc, 8'h70);
        check("pre_conflict_err", stack_err, 1'b0);
        op(1'b0, 1'b1, 1'b1, 8'h99);
        check("conflict_pc", pc, STK ? 8'h33 : 8'h99);
        check("conflict_err", stack_err, STK ? 1'b1 : 1'b0);
        check("conflict_empty", stack_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
